// File: rtl/fixedp_pkg.sv
// Shared constants for the sign-magnitude fixed-point add/sub pipeline.
// Holds the default word geometry, the all-ones magnitude and field positions.
package fixedp_pkg;

  localparam int unsigned N_DEFAULT = 32;
  localparam int unsigned Q_DEFAULT = 15;

  // Field layout of a default-width sign-magnitude word.
  localparam int unsigned SIGN_BIT = N_DEFAULT - 1;
  localparam int unsigned MAG_HI   = N_DEFAULT - 2;
  localparam int unsigned MAG_LO   = 0;
  localparam int unsigned MAG_W    = N_DEFAULT - 1;

  localparam logic [MAG_W-1:0] MAG_MAX = '1;

endpackage

// File: rtl/fixedp_sm_cmp.sv
// Stage-1 combinational datapath: magnitude compare, larger-minus-smaller and
// an add whose top result bit is the carry out of the magnitude field.
module fixedp_sm_cmp #(
  parameter int unsigned N = 32
) (
  input  logic [N-2:0] mag_a,
  input  logic [N-2:0] mag_b,
  input  logic         signs_differ,
  output logic         a_gt_b,
  output logic [N-1:0] res
);

  logic [N-1:0] sum;
  logic [N-2:0] diff;

  always_comb begin
    a_gt_b = mag_a > mag_b;
    sum    = {1'b0, mag_a} + {1'b0, mag_b};
    diff   = a_gt_b ? (mag_a - mag_b) : (mag_b - mag_a);
    res    = signs_differ ? {1'b0, diff} : sum;
  end

endmodule

// File: rtl/fixedp_sub_pipe.sv
// Two-stage sign-magnitude add/sub with saturation and valid/ready handshake.
// Optional sat_count output when FIXEDP_SUB_SATCNT_EN is defined.
module fixedp_sub_pipe
  import fixedp_pkg::*;
#(
  parameter int unsigned N = N_DEFAULT,
  parameter int unsigned Q = Q_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         op_sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] c,
`ifdef FIXEDP_SUB_SATCNT_EN
  output logic [15:0]  sat_count,
`endif
  output logic         sat
);

  if (Q > N - 1) begin : g_q_check
    $error("Q exceeds the magnitude width");
  end

  logic         cmp_a_gt_b;
  logic [N-1:0] cmp_res;
  logic         sign_b_eff;

  logic         s1_valid;
  logic         s1_sign_a;
  logic         s1_sign_b;
  logic         s1_a_gt_b;
  logic [N-1:0] s1_res;
  logic         s1_advance;

  logic         s2_diff;
  logic         res_sign;
  logic [N-1:0] c_d;
  logic         sat_d;

  assign sign_b_eff = b[N-1] ^ op_sub;

  fixedp_sm_cmp #(
    .N (N)
  ) u_cmp (
    .mag_a        (a[N-2:0]),
    .mag_b        (b[N-2:0]),
    .signs_differ (a[N-1] ^ sign_b_eff),
    .a_gt_b       (cmp_a_gt_b),
    .res          (cmp_res)
  );

  assign s1_advance = s1_valid && (!out_valid || out_ready);
  assign in_ready   = !s1_valid || s1_advance;

  // Stage-2 result formation from the registered stage-1 fields.
  always_comb begin
    s2_diff  = s1_sign_a ^ s1_sign_b;
    res_sign = (s2_diff && !s1_a_gt_b) ? s1_sign_b : s1_sign_a;
    c_d      = '0;
    sat_d    = 1'b0;
    if (!s2_diff && s1_res[N-1]) begin
      c_d   = {s1_sign_a, {(N-1){1'b1}}};
      sat_d = 1'b1;
    end else if (s1_res[N-2:0] != '0) begin
      c_d = {res_sign, s1_res[N-2:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
      c         <= '0;
      sat       <= 1'b0;
    end else begin
      if (in_ready) s1_valid <= in_valid;
      if (!out_valid || out_ready) out_valid <= s1_valid;
      if (s1_advance) begin
        c   <= c_d;
        sat <= sat_d;
      end
    end
  end

  // Payload registers need no reset; s1_valid qualifies them.
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      s1_sign_a <= a[N-1];
      s1_sign_b <= sign_b_eff;
      s1_a_gt_b <= cmp_a_gt_b;
      s1_res    <= cmp_res;
    end
  end

`ifdef FIXEDP_SUB_SATCNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sat_count <= '0;
    end else if (out_valid && out_ready && sat && (sat_count != 16'hFFFF)) begin
      sat_count <= sat_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fixedp_sub_pipe.sv
// Self-checking bench for fixedp_sub_pipe: directed literal cases, random traffic
// against an arithmetic reference model, backpressure and mid-stream reset.
module tb_fixedp_sub_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        op_sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] c;
  logic        sat;
`ifdef FIXEDP_SUB_SATCNT_EN
  logic [15:0] sat_count;
  logic [15:0] cnt_model = '0;
`endif

  int total = 0;
  int pass  = 0;

  logic [32:0] exp_q[$];
  logic [32:0] mon_e;
  logic        stall_prev = 1'b0;
  logic        rst_prev = 1'b0;
  logic [31:0] held_c;
  logic        held_sat;

  fixedp_sub_pipe #(
    .N (32),
    .Q (15)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op_sub    (op_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c         (c),
`ifdef FIXEDP_SUB_SATCNT_EN
    .sat_count (sat_count),
`endif
    .sat       (sat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [32:0] act, input logic [32:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Reference: sign-magnitude add of a and (b with sign flipped when subtracting).
  function automatic logic [32:0] model(input logic [31:0] x, input logic [31:0] y,
                                        input logic s);
    logic   sx, sy;
    longint mx, my, r;
    sx = x[31];
    sy = y[31] ^ s;
    mx = longint'(x[30:0]);
    my = longint'(y[30:0]);
    if (sx == sy) begin
      r = mx + my;
      if (r > longint'(32'h7FFF_FFFF)) return {1'b1, sx, 31'h7FFF_FFFF};
    end else if (mx >= my) begin
      r = mx - my;
    end else begin
      r  = my - mx;
      sx = sy;
    end
    if (r == 0) return 33'h0;
    return {1'b0, sx, r[30:0]};
  endfunction

  function automatic logic [31:0] rnd_op();
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(0, 4))
      0: v[30:0] = '0;
      1: v[30:0] = 31'h7FFF_FFFF - 31'($urandom_range(0, 3));
      2: v[30:0] = 31'($urandom_range(0, 255));
      default: ;
    endcase
    return v;
  endfunction

  // Scoreboard and stall-stability monitor.
  always @(negedge clk) begin
    if (stall_prev && rst_prev) begin
      chk("hold_valid", 33'(out_valid), 33'(1'b1));
      chk("hold_c", 33'(c), 33'(held_c));
      chk("hold_sat", 33'(sat), 33'(held_sat));
    end
`ifdef FIXEDP_SUB_SATCNT_EN
    if (rst_prev) chk("sat_count", 33'(sat_count), 33'(cnt_model));
`endif
    if (!rst_n) begin
      exp_q.delete();
`ifdef FIXEDP_SUB_SATCNT_EN
      cnt_model = '0;
`endif
    end else begin
      if (in_valid && in_ready) exp_q.push_back(model(a, b, op_sub));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 33'(c), 33'(1'b0) ^ 33'h1_0000_0000);
        end else begin
          mon_e = exp_q.pop_front();
          chk("sb_c", 33'(c), 33'(mon_e[31:0]));
          chk("sb_sat", 33'(sat), 33'(mon_e[32]));
`ifdef FIXEDP_SUB_SATCNT_EN
          if (mon_e[32] && cnt_model != 16'hFFFF) cnt_model = cnt_model + 16'd1;
`endif
        end
      end
    end
    stall_prev = out_valid && !out_ready;
    held_c     = c;
    held_sat   = sat;
    rst_prev   = rst_n;
  end

  // One isolated transaction: checks latency and literal result.
  task automatic directed(input string nm, input logic [31:0] ta, input logic [31:0] tb_v,
                          input logic top, input logic [31:0] ec, input logic es);
    @(posedge clk); #1;
    a = ta; b = tb_v; op_sub = top; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk({nm, "_in_ready"}, 33'(in_ready), 33'(1'b1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk({nm, "_early"}, 33'(out_valid), 33'(1'b0));
    @(negedge clk);
    chk({nm, "_valid"}, 33'(out_valid), 33'(1'b1));
    chk({nm, "_c"}, 33'(c), 33'(ec));
    chk({nm, "_sat"}, 33'(sat), 33'(es));
  endtask

  task automatic drain();
    int n;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_empty", 33'(exp_q.size()), 33'(0));
  endtask

  logic [31:0] va[4];
  logic [31:0] vb[4];
  logic        vo[4];

  initial begin
    int idx;
    // Reset and idle state, with out_ready low so in_ready cannot come from it.
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", 33'(out_valid), 33'(1'b0));
    chk("rst_c", 33'(c), 33'(0));
    chk("rst_sat", 33'(sat), 33'(1'b0));
    chk("rst_in_ready", 33'(in_ready), 33'(1'b1));

    directed("half", 32'h0001_0000, 32'h0000_8000, 1'b1, 32'h0000_8000, 1'b0);
    directed("neg", 32'h0000_8000, 32'h0001_0000, 1'b1, 32'h8000_8000, 1'b0);
    directed("add", 32'h0000_8000, 32'h0001_0000, 1'b0, 32'h0001_8000, 1'b0);
    directed("zero_sub", 32'h0000_8000, 32'h0000_8000, 1'b1, 32'h0000_0000, 1'b0);
    directed("neg_zero", 32'h8000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0);
`ifdef FIXEDP_SUB_SATCNT_EN
    chk("satcnt_before", 33'(sat_count), 33'(0));
`endif
    directed("sat_pos", 32'h7FFF_FFFF, 32'h8000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1);
    @(negedge clk);
`ifdef FIXEDP_SUB_SATCNT_EN
    chk("satcnt_after", 33'(sat_count), 33'(1));
`endif
    directed("sat_neg", 32'hFFFF_FFFF, 32'h8000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1);
    directed("tie_mag", 32'h8000_1234, 32'h8000_1234, 1'b1, 32'h0000_0000, 1'b0);
    drain();

    // Random traffic with random backpressure.
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      a         = rnd_op();
      b         = ($urandom_range(0, 7) == 0) ? (a ^ {($urandom_range(0, 1) == 1), 31'h0})
                                              : rnd_op();
      op_sub    = ($urandom_range(0, 1) == 1);
    end
    drain();

    // Backpressure: four back-to-back pairs, out_ready low for six cycles.
    for (int i = 0; i < 4; i++) begin
      va[i] = rnd_op(); vb[i] = rnd_op(); vo[i] = ($urandom_range(0, 1) == 1);
    end
    idx = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(posedge clk); #1;
      out_ready = (cyc >= 6);
      in_valid  = (idx < 4);
      if (idx < 4) begin
        a = va[idx]; b = vb[idx]; op_sub = vo[idx];
      end
      @(negedge clk);
      if (cyc >= 6 && cyc < 10) chk("bp_no_gap", 33'(out_valid), 33'(1'b1));
      if (cyc == 2) chk("bp_in_ready_low", 33'(in_ready), 33'(1'b0));
      if (in_valid && in_ready) idx++;
      if (cyc == 5) chk("bp_accepted", 33'(idx), 33'(2));
    end
    chk("bp_all_accepted", 33'(idx), 33'(4));
    drain();

    // Mid-stream reset with both stages full.
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1;
    a = 32'h0000_1111; b = 32'h0000_2222; op_sub = 1'b0;
    @(posedge clk); #1;
    a = 32'h8000_0333; b = 32'h0000_0444; op_sub = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_full", 33'(out_valid), 33'(1'b1));
    @(posedge clk); #1;
    rst_n = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mrst_out_valid", 33'(out_valid), 33'(1'b0));
    chk("mrst_c", 33'(c), 33'(0));
    chk("mrst_sat", 33'(sat), 33'(1'b0));
    chk("mrst_in_ready", 33'(in_ready), 33'(1'b1));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("mrst_quiet", 33'(out_valid), 33'(1'b0));
    end
    directed("post_rst", 32'h0000_0001, 32'h0000_0002, 1'b0, 32'h0000_0003, 1'b0);
    drain();

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
